fdivsqrtrecode4: RTL and testbench
==================================

// Module: fdivsqrtrecode4
// PURPOSE
//  Radix-4 signed-digit serializer: the inverse of the radix-4 on-the-fly converter.
//  - Loads a W-bit two's-complement value X.
//  - Emits X MSB-first as one-hot radix-4 digits {+2,+1,0,-1,-2}, one per handshake.
//  - Each digit comes with the running C mask, so udigit/C drive the unified OTFC directly.
//  - Used in fdivsqrt testbenches and self-check logic to replay a known quotient/root through the OTFC.
// PARAMETERS
//  P    cvw_t (config)        design configuration; only P.DIVb is used
//  W    P.DIVb+1 (localparam) input/C width
//  WE   W+(W%2) (localparam)  even width after 1-bit sign extension
//  ND   WE/2 (localparam)     digits per value
// PORTS
//  clk      in   1       clock
//  reset    in   1       synchronous active-high reset
//  Start    in   1       load X; accepted only when Busy=0
//  X        in   W       value to recode (two's complement)
//  Busy     out  1       value loaded and digits still to be emitted
//  DigValid out  1       udigit/C/Last are valid
//  DigReady in   1       consumer accepts the digit this cycle
//  udigit   out  4       one-hot digit: [3]=+2, [2]=+1, [1]=-1, [0]=-2, 0000=0
//  C        out  W       mask; bits [W-1 : WE-2-2j] set for digit j
//  Last     out  1       current digit is digit ND-1
//  Mismatch out  1       self-check failure flag; present only with the feature enabled
// BEHAVIOUR
//  - Clock and reset
//    - Single clock, clk.
//    - reset is synchronous and active-high.
//    - Reset values: Busy=0, DigValid=0, udigit=0, C=0, Last=0, Mismatch=0, digit counter j=0.
//    - Reset asserted mid-value aborts the sequence immediately. No further digits are emitted.
//  - FSM states
//    - IDLE --Start--> RUN
//    - RUN --(DigValid & DigReady & Last)--> IDLE
//    - Start in RUN is ignored.
//    - Start and the final accept in the same cycle: the accept completes, Start is dropped. The source re-asserts Start.
//  - Load (IDLE & Start): register Xe = {X[W-1] if W odd, X} and append b[-1]=0.
//  - Latency: the first digit is valid the cycle after Start.
//  - One digit is emitted per accepted handshake.
//  - Digit recoding (Booth)
//    - d_j = -2*b[WE-1-2j] + b[WE-2-2j] + b[WE-3-2j], for j = 0..ND-1.
//    - Bits below index 0 read as 0.
//    - d_j weight = 2^(WE-2-2j).
//    - For odd W, d_0 is in {-1,0,+1}, because the top two padded bits are equal.
//  - Mask C
//    - Digit 0: C = bits [W-1 : WE-2] set.
//    - Each accept: C <= (C >> 2) with ones shifted in at the top.
//    - For W odd, digit 0 has C = only bit W-1 set.
//    - K1 = C & ~(C<<1) marks the digit LSB weight.
//  - Handshake
//    - DigValid=1 for the whole of RUN.
//    - udigit, C and Last are held stable while DigValid & ~DigReady (no bubbles, no drops).
//    - On accept, j increments and the next digit appears the next cycle.
//  - Busy = RUN.
//  - After the final accept, DigValid drops the next cycle.
//  - Invariant: feeding the digits into the OTFC, starting from U=UM=0, yields U == X mod 2^W.
// CONFIGURATION
//  FDIVSQRT_RECODE_CHECK_EN defined:
//    - Adds an internal U/UM accumulator that applies the OTFC update on each accept.
//    - Also adds a W-bit copy of X.
//    - On the final accept, Mismatch is set if U != X.
//    - Mismatch stays set until reset or the next Start.
//  FDIVSQRT_RECODE_CHECK_EN undefined:
//    - No accumulator and no copy of X.
//    - Mismatch is tied to 0.
//    - The digit stream is cycle-identical to the defined build.
// TESTING
//  1. X=0, DigReady=1 -> ND digits all udigit=0000; Last only on digit ND-1; Busy=0 one cycle after it.
//  2. X=1 -> digits 0..ND-2 = 0000, last digit = 0100 (+1).
//  3. X=all ones (-1) -> all 0000 except last = 0010 (-1).
//  4. X=0x55..5 (W even) -> every digit 0100 (+1).
//  5. X=0xAA..A (W even) -> digits 0..ND-2 = 0010 (-1), last = 0001 (-2).
//  6. Random X with DigReady toggling randomly, plus Start pulses while Busy:
//     - outputs stay stable while stalled;
//     - the extra Starts are ignored;
//     - the OTFC model reconstructs X;
//     - with FDIVSQRT_RECODE_CHECK_EN, Mismatch=0.
//  7. Reset asserted after 3 accepts -> next cycle Busy=0, DigValid=0; the next Start begins again at digit 0.

Source files
------------

// File: rtl/fdivsqrtrecode4.sv
// fdivsqrtrecode4: radix-4 signed-digit serializer, the inverse of the radix-4
// on-the-fly converter. A loaded two's-complement value X is emitted MSB-first
// as Booth-recoded one-hot digits {+2,+1,0,-1,-2}, one per valid/ready handshake,
// each paired with the running C mask so udigit/C can drive the unified OTFC.
// Optional feature macro: FDIVSQRT_RECODE_CHECK_EN adds an internal OTFC
// accumulator that rebuilds X from the emitted digits and flags Mismatch.
module fdivsqrtrecode4 #(
    parameter int DIVb = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [DIVb:0]   X,
    output logic            Busy,
    output logic            DigValid,
    input  logic            DigReady,
    output logic [3:0]      udigit,
    output logic [DIVb:0]   C,
    output logic            Last,
    output logic            Mismatch
);

    localparam int W  = DIVb + 1;
    localparam int WE = W + (W % 2);
    localparam int ND = WE / 2;
    localparam int JW = (ND > 1) ? $clog2(ND) : 1;

    localparam logic [W-1:0] ONES   = '1;
    // Digit 0 covers bits [W-1 : WE-2]: two bits for even W, one for odd W.
    localparam logic [W-1:0] C_INIT = ~(ONES >> (W - WE + 2));
    localparam logic [W-1:0] C_TOP2 = ~(ONES >> 2);

    localparam logic [3:0] DIG_P2 = 4'b1000;
    localparam logic [3:0] DIG_P1 = 4'b0100;
    localparam logic [3:0] DIG_Z  = 4'b0000;
    localparam logic [3:0] DIG_M1 = 4'b0010;
    localparam logic [3:0] DIG_M2 = 4'b0001;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    // Sign-extended value with the implicit b[-1]=0 appended at bit 0; the
    // current Booth triple always sits in the top three bits.
    logic [WE:0]      xe_q, xe_d;
    logic [W-1:0]     c_q, c_d;
    logic [JW-1:0]    j_q, j_d;

    logic signed [WE-1:0] xe_load;
    logic                 run;
    logic                 last_dig;
    logic                 accept;
    logic [3:0]           booth;

    assign xe_load  = $signed(X);
    assign run      = (state_q == RUN);
    assign last_dig = (j_q == JW'(ND - 1));
    assign accept   = run & DigReady;

    // Booth-recode the top triple {b[2j'+1], b[2j'], b[2j'-1]} into a one-hot digit.
    always_comb begin
        unique case (xe_q[WE:WE-2])
            3'b001, 3'b010: booth = DIG_P1;
            3'b011:         booth = DIG_P2;
            3'b100:         booth = DIG_M2;
            3'b101, 3'b110: booth = DIG_M1;
            default:        booth = DIG_Z;
        endcase
    end

    // Next-state logic for the FSM and the digit datapath.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        xe_d    = xe_q;
        c_d     = c_q;
        j_d     = j_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    xe_d    = {xe_load, 1'b0};
                    c_d     = C_INIT;
                    j_d     = '0;
                end
            end
            RUN: begin
                // Start is ignored here, including on the final accept.
                if (DigReady) begin
                    if (last_dig) begin
                        state_d = IDLE;
                        xe_d    = '0;
                        c_d     = '0;
                        j_d     = '0;
                    end else begin
                        xe_d = xe_q << 2;
                        c_d  = (c_q >> 2) | C_TOP2;
                        j_d  = j_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any sequence.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            xe_q    <= '0;
            c_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            xe_q    <= xe_d;
            c_q     <= c_d;
            j_q     <= j_d;
        end
    end

    assign Busy     = run;
    assign DigValid = run;
    assign udigit   = run ? booth : DIG_Z;
    assign C        = c_q;
    assign Last     = run & last_dig;

`ifdef FDIVSQRT_RECODE_CHECK_EN
    logic [W-1:0] u_q, um_q, xc_q;
    logic [W-1:0] u_d, um_d;
    logic [W-1:0] k1, k3;
    logic         mismatch_q;

    assign k1 = c_q & ~(c_q << 1);
    assign k3 = k1 | (k1 << 1);

    // OTFC update for the digit currently presented, weight marked by k1.
    always_comb begin
        u_d  = u_q;
        um_d = um_q;
        unique case (booth)
            DIG_P2: begin u_d = u_q  | (k1 << 1); um_d = u_q  | k1;        end
            DIG_P1: begin u_d = u_q  | k1;        um_d = u_q;              end
            DIG_M1: begin u_d = um_q | k3;        um_d = um_q | (k1 << 1); end
            DIG_M2: begin u_d = um_q | (k1 << 1); um_d = um_q | k1;        end
            default: begin u_d = u_q;             um_d = um_q | k3;        end
        endcase
    end

    // Accumulate on each accept; compare against the captured X on the final one.
    always_ff @(posedge clk) begin
        if (reset) begin
            u_q        <= '0;
            um_q       <= '0;
            xc_q       <= '0;
            mismatch_q <= 1'b0;
        end else if (!run && Start) begin
            u_q        <= '0;
            um_q       <= '0;
            xc_q       <= X;
            mismatch_q <= 1'b0;
        end else if (accept) begin
            u_q  <= u_d;
            um_q <= um_d;
            if (last_dig) mismatch_q <= (u_d != xc_q);
        end
    end

    assign Mismatch = mismatch_q;
`else
    assign Mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_fdivsqrtrecode4.sv
// Testbench for fdivsqrtrecode4: directed and random values, random back-pressure,
// stray Start pulses while busy, and a mid-sequence reset. Expected digits come
// from the Booth formula; a monitor pops them on every handshake and also rebuilds
// X from the observed digit values and weights.
module tb_fdivsqrtrecode4;

    localparam int DIVb = 7;
    localparam int W    = DIVb + 1;
    localparam int WE   = W + (W % 2);
    localparam int ND   = WE / 2;

    typedef struct {
        logic [3:0]   ud;
        logic [W-1:0] c;
        logic         last;
    } dig_t;

    logic         clk = 1'b0;
    logic         reset, Start, DigReady;
    logic [W-1:0] X;
    logic         Busy, DigValid, Last, Mismatch;
    logic [3:0]   udigit;
    logic [W-1:0] C;

    int checks = 0;
    int errors = 0;

    dig_t         sb[$];
    logic [W-1:0] xq[$];

    fdivsqrtrecode4 #(.DIVb(DIVb)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .X        (X),
        .Busy     (Busy),
        .DigValid (DigValid),
        .DigReady (DigReady),
        .udigit   (udigit),
        .C        (C),
        .Last     (Last),
        .Mismatch (Mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit i of the sign-extended value, with bits below 0 reading as 0.
    function automatic int xbit(input logic [W-1:0] x, input int i);
        if (i < 0) return 0;
        if (i >= W) return int'(x[W-1]);
        return int'(x[i]);
    endfunction

    function automatic int ref_digit(input logic [W-1:0] x, input int j);
        return -2 * xbit(x, WE-1-2*j) + xbit(x, WE-2-2*j) + xbit(x, WE-3-2*j);
    endfunction

    function automatic logic [3:0] onehot(input int d);
        case (d)
            2:  return 4'b1000;
            1:  return 4'b0100;
            -1: return 4'b0010;
            -2: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int digit_value(input logic [3:0] u);
        case (u)
            4'b1000: return 2;
            4'b0100: return 1;
            4'b0010: return -1;
            4'b0001: return -2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_mask(input int j);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (i >= WE-2-2*j);
        return m;
    endfunction

    task automatic push_expected(input logic [W-1:0] x);
        dig_t e;
        for (int j = 0; j < ND; j++) begin
            e.ud   = onehot(ref_digit(x, j));
            e.c    = ref_mask(j);
            e.last = (j == ND - 1);
            sb.push_back(e);
        end
        xq.push_back(x);
    endtask

    // Monitor: compares on every handshake, checks stall stability and idle after Last.
    logic         stall_v = 1'b0;
    logic         expect_idle = 1'b0;
    logic [3:0]   p_ud;
    logic [W-1:0] p_c;
    logic         p_last;
    longint       recon = 0;
    int           jmon = 0;

    always @(negedge clk) begin
        dig_t         e;
        logic [W-1:0] xr;
        if (reset) begin
            stall_v     = 1'b0;
            expect_idle = 1'b0;
            recon       = 0;
            jmon        = 0;
        end else begin
            if (expect_idle) begin
                check("busy_after_last", Busy, 0);
                check("valid_after_last", DigValid, 0);
                check("mismatch_flag", Mismatch, 0);
                expect_idle = 1'b0;
            end
            if (stall_v && DigValid) begin
                check("stall_udigit", udigit, p_ud);
                check("stall_c", C, p_c);
                check("stall_last", Last, p_last);
            end
            stall_v = DigValid && !DigReady;
            p_ud    = udigit;
            p_c     = C;
            p_last  = Last;
            if (DigValid && DigReady) begin
                if (sb.size() == 0) begin
                    check("unexpected_digit", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("udigit", udigit, e.ud);
                    check("c_mask", C, e.c);
                    check("last", Last, e.last);
                    recon += longint'(digit_value(udigit)) * (longint'(1) << (WE-2-2*jmon));
                    jmon++;
                    if (e.last) begin
                        xr = W'(recon);
                        if (xq.size() > 0) check("otfc_recon", xr, xq.pop_front());
                        recon       = 0;
                        jmon        = 0;
                        expect_idle = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one value; random mode toggles DigReady and throws in ignored Starts.
    task automatic send(input logic [W-1:0] x, input bit rnd);
        int budget;
        budget = 0;
        while (Busy && budget < 100) begin tick(); budget++; end
        if (Busy) check("wait_idle_timeout", 1, 0);
        Start = 1'b1;
        X     = x;
        push_expected(x);
        DigReady = rnd ? 1'($urandom) : 1'b1;
        tick();
        Start  = 1'b0;
        budget = 0;
        while (Busy && budget < 200) begin
            if (rnd) begin
                DigReady = 1'($urandom);
                Start    = ($urandom_range(0, 3) == 0);
                X        = W'($urandom);
            end
            tick();
            budget++;
        end
        Start = 1'b0;
        if (Busy) check("sequence_timeout", 1, 0);
    endtask

    initial begin
        logic [W-1:0] fives, aas, x;
        int           budget;
        reset = 1'b1; Start = 1'b0; DigReady = 1'b0; X = '0;
        repeat (2) tick();
        check("rst_busy", Busy, 0);
        check("rst_valid", DigValid, 0);
        check("rst_udigit", udigit, 0);
        check("rst_c", C, 0);
        check("rst_last", Last, 0);
        check("rst_mismatch", Mismatch, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < W; i++) begin
            fives[i] = (i % 2 == 0);
            aas[i]   = (i % 2 == 1);
        end
        send('0, 1'b0);
        send(W'(1), 1'b0);
        send('1, 1'b0);
        send(fives, 1'b0);
        send(aas, 1'b0);

        for (int n = 0; n < 40; n++) send(W'($urandom), 1'b1);

        // Reset after three accepts, then confirm a fresh start at digit 0.
        tick();
        DigReady = 1'b1;
        x = W'($urandom);
        Start = 1'b1; X = x;
        push_expected(x);
        tick();
        Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_valid", DigValid, 0);
        sb.delete();
        xq.delete();
        send(aas ^ W'(3), 1'b0);
        send(W'($urandom), 1'b1);

        budget = 0;
        while (sb.size() != 0 && budget < 50) begin tick(); budget++; end
        repeat (2) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
